// File: rtl/alu_cmd_seq.sv
// Operand/opcode entry sequencer in front of a combinational ALU.
// Conditions the enter/clear buttons, walks A -> B -> OP -> EXEC -> SHOW,
// and captures the ALU result and flags for display.
module alu_cmd_seq #(
   parameter int unsigned DB_CYCLES = 16,
   parameter int unsigned DATA_W    = 4,
   parameter int unsigned OP_W      = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sw,
   input  logic [OP_W-1:0]   op_sw,
   input  logic              btn,
   input  logic              clr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   input  logic              alu_overflow,
   input  logic              alu_zero,
   output logic [DATA_W-1:0] res_q,
   output logic              carry_q,
   output logic              overflow_q,
   output logic              zero_q,
   output logic              res_valid,
   output logic [2:0]        state_o
);

   localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam int unsigned NBTN  = 2;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   // Button conditioning: index 0 = btn, index 1 = clr
   logic [NBTN-1:0]  raw;
   logic [NBTN-1:0]  sync1;
   logic [NBTN-1:0]  sync2;
   logic [NBTN-1:0]  stable;
   logic [NBTN-1:0]  press;
   logic [CNT_W-1:0] cnt [NBTN];
   logic             btn_press;
   logic             clr_press;

   assign raw       = {clr, btn};
   assign btn_press = press[0];
   assign clr_press = press[1];

   // Two-flop synchroniser, debounce counter and registered rising-edge pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         press  <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < NBTN; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
               press[i]  <= sync2[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Entry FSM and datapath registers
   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_r, res_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              c_q, c_d, v_q, v_d, z_q, z_d, valid_q, valid_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_A;
      else        state_q <= state_d;
   end

   // Next-state logic; clear wins over enter
   always_comb begin
      state_d = state_q;
      if (clr_press) begin
         state_d = S_A;
      end else begin
         case (state_q)
            S_A:     if (btn_press) state_d = S_B;
            S_B:     if (btn_press) state_d = S_OP;
            S_OP:    if (btn_press) state_d = S_EXEC;
            S_EXEC:  state_d = S_SHOW;
            S_SHOW:  if (btn_press) state_d = S_A;
            default: state_d = S_A;
         endcase
      end
   end

   // Next values of operand, opcode and result registers
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_r;
      c_d     = c_q;
      v_d     = v_q;
      z_d     = z_q;
      valid_d = valid_q;
      if (clr_press) begin
         a_d     = '0;
         b_d     = '0;
         op_d    = '0;
         res_d   = '0;
         c_d     = 1'b0;
         v_d     = 1'b0;
         z_d     = 1'b0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_A: if (btn_press) begin
               a_d     = sw;
               valid_d = 1'b0;
            end
            S_B:  if (btn_press) b_d  = sw;
            S_OP: if (btn_press) op_d = op_sw;
            S_EXEC: begin
               res_d   = alu_result;
               c_d     = alu_carry;
               v_d     = alu_overflow;
               z_d     = alu_zero;
               valid_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_r   <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_r   <= res_d;
         c_q     <= c_d;
         v_q     <= v_d;
         z_q     <= z_d;
         valid_q <= valid_d;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign res_q      = res_r;
   assign carry_q    = c_q;
   assign overflow_q = v_q;
   assign zero_q     = z_q;
   assign res_valid  = valid_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq with a behavioural 4-bit ALU behind it and a
// press-level reference model of the entry sequence.
module tb_alu_cmd_seq;

   localparam int unsigned DB = 4;
   localparam int unsigned DW = 4;
   localparam int unsigned OW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] sw;
   logic [OW-1:0] op_sw;
   logic          btn, clr;
   logic [DW-1:0] alu_a, alu_b, alu_result, res_q;
   logic [OW-1:0] alu_op;
   logic          alu_carry, alu_overflow, alu_zero;
   logic          carry_q, overflow_q, zero_q, res_valid;
   logic [2:0]    state_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int            m_state;
   logic [DW-1:0] m_a, m_b, m_res;
   logic [OW-1:0] m_op;
   logic          m_c, m_v, m_z, m_valid;

   always #5 clk = ~clk;

   alu_cmd_seq #(.DB_CYCLES(DB), .DATA_W(DW), .OP_W(OW)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .op_sw(op_sw), .btn(btn), .clr(clr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .res_q(res_q), .carry_q(carry_q), .overflow_q(overflow_q),
      .zero_q(zero_q), .res_valid(res_valid), .state_o(state_o)
   );

   // Lab ALU: returns {carry, overflow, zero, result}
   function automatic logic [6:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
      logic [4:0] s;
      logic [3:0] r;
      logic       c, v;
      s = 5'd0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[3:0]; c = s[4];
            v = (a[3] == b[3]) && (r[3] != a[3]);
         end
         3'd1: begin
            s = {1'b0, a} + {1'b0, ~b} + 5'd1;
            r = s[3:0]; c = s[4];
            v = (a[3] != b[3]) && (r[3] != a[3]);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: r = {3'b000, ($signed(a) < $signed(b))};
         default: r = {3'b000, (a == b)};
      endcase
      return {c, v, (r == 4'd0), r};
   endfunction

   always_comb {alu_carry, alu_overflow, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_op);

   task automatic model_reset();
      m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0;
      m_c = 0; m_v = 0; m_z = 0; m_valid = 0;
   endtask

   // One accepted press: clear beats enter; an OP press runs through EXEC into SHOW
   task automatic model_press(input bit b, input bit c);
      logic [6:0] r;
      if (c) begin
         model_reset();
      end else if (b) begin
         case (m_state)
            0: begin m_a = sw; m_valid = 0; m_state = 1; end
            1: begin m_b = sw; m_state = 2; end
            2: begin
               m_op = op_sw;
               r = alu_f(m_a, m_b, m_op);
               {m_c, m_v, m_z, m_res} = r;
               m_valid = 1; m_state = 4;
            end
            default: m_state = 0;
         endcase
      end
   endtask

   // Clean 10-cycle press on btn and/or clr, then idle long enough to settle
   task automatic pulse(input bit b, input bit c);
      @(negedge clk);
      btn = b; clr = c;
      repeat (10) @(negedge clk);
      btn = 0; clr = 0;
      repeat (DB + 6) @(negedge clk);
      model_press(b, c);
   endtask

   task automatic test_reset();
      rst_n = 0; btn = 0; clr = 0; sw = '0; op_sw = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (20) @(negedge clk);
      checks++;
      if ({state_o, res_valid, alu_a, alu_b, alu_op, res_q, carry_q, overflow_q, zero_q} !== 23'd0) begin
         errors++;
         $display("FAIL reset_idle: got state=%0d valid=%b a=%0d b=%0d op=%0d res=%0d cvz=%b%b%b, want all 0",
                  state_o, res_valid, alu_a, alu_b, alu_op, res_q, carry_q, overflow_q, zero_q);
      end
      sw = 4'd9; pulse(1, 0);
      sw = 4'd6; pulse(1, 0);
      checks++;
      if (state_o !== 3'd2) begin
         errors++; $display("FAIL reset_reach_op: got state=%0d want 2", state_o);
      end
      #2 rst_n = 0;
      #1;
      model_reset();
      checks++;
      if ({state_o, res_valid, alu_a, alu_b, alu_op, res_q} !== 19'd0) begin
         errors++;
         $display("FAIL reset_async: got state=%0d valid=%b a=%0d b=%0d op=%0d res=%0d want all 0",
                  state_o, res_valid, alu_a, alu_b, alu_op, res_q);
      end
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_add();
      sw = 4'd3; pulse(1, 0);
      sw = 4'd5; pulse(1, 0);
      op_sw = 3'd0;
      @(negedge clk);
      btn = 1;
      repeat (DB + 2) @(posedge clk);
      #1;
      checks++;
      if (state_o !== 3'd2) begin
         errors++; $display("FAIL add_pre_exec: got state=%0d want 2", state_o);
      end
      @(posedge clk); #1;
      checks++;
      if ({state_o, alu_a, alu_b, alu_op, res_valid} !== {3'd3, 4'd3, 4'd5, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL add_exec: got state=%0d a=%0d b=%0d op=%0d valid=%b want 3/3/5/0/0",
                  state_o, alu_a, alu_b, alu_op, res_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({state_o, res_q, carry_q, overflow_q, zero_q, res_valid} !== {3'd4, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL add_result: got state=%0d res=%0d c=%b v=%b z=%b valid=%b want 4/8/0/1/0/1",
                  state_o, res_q, carry_q, overflow_q, zero_q, res_valid);
      end
      repeat (2) @(negedge clk);
      btn = 0;
      repeat (DB + 6) @(negedge clk);
      model_press(1, 0);
   endtask

   task automatic test_wrap();
      pulse(1, 0);
      checks++;
      if ({state_o, res_valid, res_q} !== {3'd0, 1'b1, 4'd8}) begin
         errors++;
         $display("FAIL wrap_to_a: got state=%0d valid=%b res=%0d want 0/1/8", state_o, res_valid, res_q);
      end
      sw = 4'd7; pulse(1, 0);
      checks++;
      if ({state_o, alu_a, res_valid} !== {3'd1, 4'd7, 1'b0}) begin
         errors++;
         $display("FAIL wrap_capture: got state=%0d a=%0d valid=%b want 1/7/0", state_o, alu_a, res_valid);
      end
      pulse(0, 1);
   endtask

   task automatic test_sub();
      logic [2:0] ops [2];
      logic [3:0] want [2];
      ops[0] = 3'd1; ops[1] = 3'd7;
      want[0] = 4'd0; want[1] = 4'd1;
      for (int k = 0; k < 2; k++) begin
         sw = 4'd5; pulse(1, 0);
         sw = 4'd5; pulse(1, 0);
         op_sw = ops[k]; pulse(1, 0);
         checks++;
         if (res_q !== want[k] || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL sub_eq_res op=%0d: got res=%0d valid=%b want %0d/1", ops[k], res_q, res_valid, want[k]);
         end
         if (k == 0) begin
            checks++;
            if ({carry_q, overflow_q, zero_q} !== 3'b101) begin
               errors++;
               $display("FAIL sub_flags: got cvz=%b%b%b want 101", carry_q, overflow_q, zero_q);
            end
         end
         pulse(1, 0);
      end
   endtask

   task automatic test_bounce();
      int st0;
      st0 = m_state;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); btn = 1;
         @(negedge clk);
         @(negedge clk); btn = 0;
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (state_o !== 3'(st0)) begin
         errors++; $display("FAIL bounce_no_press: got state=%0d want %0d", state_o, st0);
      end
      sw = 4'd11;
      @(negedge clk); btn = 1;
      repeat (100) @(negedge clk);
      btn = 0;
      repeat (DB + 6) @(negedge clk);
      model_press(1, 0);
      checks++;
      if (state_o !== 3'(m_state) || alu_a !== m_a) begin
         errors++;
         $display("FAIL hold_one_press: got state=%0d a=%0d want %0d/%0d", state_o, alu_a, m_state, m_a);
      end
   endtask

   task automatic test_clear();
      pulse(0, 1);
      sw = 4'd3; pulse(1, 0);
      sw = 4'd5; pulse(1, 0);
      op_sw = 3'd0; pulse(1, 0);
      pulse(0, 1);
      checks++;
      if ({state_o, res_valid, res_q, carry_q, overflow_q, zero_q} !== 12'd0) begin
         errors++;
         $display("FAIL clr_show: got state=%0d valid=%b res=%0d cvz=%b%b%b want all 0",
                  state_o, res_valid, res_q, carry_q, overflow_q, zero_q);
      end
      sw = 4'd3; pulse(1, 0);
      sw = 4'd5; pulse(1, 0);
      op_sw = 3'd0; pulse(1, 0);
      pulse(1, 0);
      sw = 4'd2; pulse(1, 0);
      pulse(0, 1);
      checks++;
      if ({state_o, res_valid, res_q, alu_a} !== 12'd0) begin
         errors++;
         $display("FAIL clr_in_b: got state=%0d valid=%b res=%0d a=%0d want 0/0/0/0",
                  state_o, res_valid, res_q, alu_a);
      end
      sw = 4'd9; pulse(1, 1);
      checks++;
      if (state_o !== 3'd0 || alu_a !== 4'd0) begin
         errors++;
         $display("FAIL clr_btn_together: got state=%0d a=%0d want 0/0", state_o, alu_a);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         for (int p = 0; p < 4; p++) begin
            sw = 4'($urandom_range(0, 15));
            op_sw = 3'($urandom_range(0, 7));
            pulse(1, 0);
            checks++;
            if ({state_o, alu_a, alu_b, alu_op, res_q, carry_q, overflow_q, zero_q, res_valid} !==
                {3'(m_state), m_a, m_b, m_op, m_res, m_c, m_v, m_z, m_valid}) begin
               errors++;
               $display("FAIL random n=%0d p=%0d: got st=%0d a=%0d b=%0d op=%0d res=%0d cvz=%b%b%b val=%b want st=%0d a=%0d b=%0d op=%0d res=%0d cvz=%b%b%b val=%b",
                        n, p, state_o, alu_a, alu_b, alu_op, res_q, carry_q, overflow_q, zero_q, res_valid,
                        m_state, m_a, m_b, m_op, m_res, m_c, m_v, m_z, m_valid);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_wrap();
      test_sub();
      test_bounce();
      test_clear();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
